// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC mode controller: FSM states, mode codes
// and a constant-evaluable ceil(log2) used to size counters.
package rtc_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        RD,
        PROG,
        WB
    } rtc_state_e;

    localparam logic [1:0] MODE_IDLE  = 2'd0;
    localparam logic [1:0] MODE_DATE  = 2'd1;
    localparam logic [1:0] MODE_TIME  = 2'd2;
    localparam logic [1:0] MODE_TIMER = 2'd3;

    // Smallest r with 2**r >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rtc_mode_ctrl_if.sv
// Handshake between the mode controller (master) and the RTC
// bus-transaction unit (slave). bus_start is a one-cycle request and
// bus_wr qualifies it; bus_done is a one-cycle completion pulse.
interface rtc_mode_ctrl_if;

    logic bus_busy;
    logic bus_done;
    logic bus_start;
    logic bus_wr;

    modport master (
        output bus_start,
        output bus_wr,
        input  bus_busy,
        input  bus_done
    );

    modport slave (
        input  bus_start,
        input  bus_wr,
        output bus_busy,
        output bus_done
    );

endinterface

// File: rtl/rtc_sw_debounce.sv
// Two-flop synchroniser followed by a stability filter: q_o only takes the
// synchronised vector once it has held the same value for DEBOUNCE_CYC
// consecutive cycles, giving 2 + DEBOUNCE_CYC cycles from sw edge to q_o.
module rtc_sw_debounce import rtc_pkg::*; #(
    parameter int W            = 3,
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic         clk,
    input  logic         swreset,
    input  logic [W-1:0] sw_i,
    output logic [W-1:0] q_o
);

    localparam int CW = (clog2(DEBOUNCE_CYC + 1) < 1) ? 1 : clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC);

    logic [W-1:0]  sync1_q;
    logic [W-1:0]  sync2_q;
    logic [W-1:0]  cand_q;
    logic [W-1:0]  q_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Number of consecutive cycles the synchronised vector has held; a change restarts at 1.
    always_comb begin
        cnt_d = cnt_q;
        if (sync2_q != cand_q) begin
            cnt_d = CW'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Synchroniser stages, stability history and qualified-vector update.
    always_ff @(posedge clk or posedge swreset) begin
        if (swreset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
        end else begin
            sync1_q <= sw_i;
            sync2_q <= sync1_q;
            cand_q  <= sync2_q;
            cnt_q   <= cnt_d;
            if (cnt_d == CNT_MAX) begin
                q_q <= sync2_q;
            end
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/rtc_mode_ctrl.sv
// Main RTC control FSM: configuration writes after reset, periodic refresh
// reads while idle, mode selection from debounced switches and a write-back
// transaction whenever a programming mode is left. A request is launched
// on the cycle after bus_busy was sampled low, and every wait for bus_done
// is bounded by TIMEOUT_CYC, after which bus_err sticks until swreset.
module rtc_mode_ctrl import rtc_pkg::*; #(
    parameter int N_MODES      = 3,
    parameter int MODE_W       = 2,
    parameter int DEBOUNCE_CYC = 4,
    parameter int REFRESH_CYC  = 100,
    parameter int INIT_WRITES  = 2,
    parameter int TIMEOUT_CYC  = 64
) (
    input  logic               clk,
    input  logic               swreset,
    input  logic [N_MODES-1:0] sw,
    rtc_mode_ctrl_if.master    bus,
    output logic [MODE_W-1:0]  out,
    output logic               init_done,
    output logic               bus_err
);

    localparam int RW = (clog2(REFRESH_CYC) < 1) ? 1 : clog2(REFRESH_CYC);
    localparam int TW = (clog2(TIMEOUT_CYC) < 1) ? 1 : clog2(TIMEOUT_CYC);
    localparam int IW = (clog2(INIT_WRITES + 1) < 1) ? 1 : clog2(INIT_WRITES + 1);
    localparam logic [RW-1:0] RF_LAST = RW'(REFRESH_CYC - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    rtc_state_e         state_q;
    logic               wait_q;
    logic [RW-1:0]      ref_cnt_q;
    logic [TW-1:0]      to_cnt_q;
    logic [IW-1:0]      init_cnt_q;
    logic [MODE_W-1:0]  out_q;
    logic               start_q;
    logic               wr_q;
    logic               init_done_q;
    logic               err_q;
    logic [N_MODES-1:0] prog_vec_q;

    logic [N_MODES-1:0] q_vec;
    logic [MODE_W-1:0]  sel_code;
    logic               sel_valid;
    logic               xfer_end;
    logic               timeout_hit;

    rtc_sw_debounce #(
        .W            (N_MODES),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
        .clk     (clk),
        .swreset (swreset),
        .sw_i    (sw),
        .q_o     (q_vec)
    );

    // Lowest set switch wins (date over time over timer); code is index + 1.
    always_comb begin
        sel_code = '0;
        for (int i = N_MODES - 1; i >= 0; i--) begin
            if (q_vec[i]) sel_code = MODE_W'(i + 1);
        end
    end

    assign sel_valid   = |q_vec;
    assign xfer_end    = wait_q && (bus.bus_done || (to_cnt_q == TO_LAST));
    assign timeout_hit = wait_q && !bus.bus_done && (to_cnt_q == TO_LAST);

    // Control FSM with registered outputs; a timeout finishes a wait exactly like bus_done.
    always_ff @(posedge clk or posedge swreset) begin
        if (swreset) begin
            state_q     <= INIT;
            wait_q      <= 1'b0;
            ref_cnt_q   <= '0;
            to_cnt_q    <= '0;
            init_cnt_q  <= '0;
            out_q       <= '0;
            start_q     <= 1'b0;
            wr_q        <= 1'b0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
            prog_vec_q  <= '0;
        end else begin
            start_q <= 1'b0;
            wr_q    <= 1'b0;
            if (wait_q) to_cnt_q <= to_cnt_q + 1'b1;
            if (timeout_hit) err_q <= 1'b1;
            if (xfer_end) begin
                wait_q   <= 1'b0;
                to_cnt_q <= '0;
            end
            case (state_q)
                INIT: begin
                    if (INIT_WRITES == 0) begin
                        init_done_q <= 1'b1;
                        state_q     <= IDLE;
                    end else if (!wait_q) begin
                        if (!bus.bus_busy) begin
                            start_q <= 1'b1;
                            wr_q    <= 1'b1;
                            wait_q  <= 1'b1;
                        end
                    end else if (xfer_end) begin
                        init_cnt_q <= init_cnt_q + 1'b1;
                        if (int'(init_cnt_q) + 1 == INIT_WRITES) begin
                            init_done_q <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end
                end
                IDLE: begin
                    out_q <= MODE_W'(MODE_IDLE);
                    if (sel_valid) begin
                        state_q    <= PROG;
                        out_q      <= sel_code;
                        prog_vec_q <= q_vec;
                        ref_cnt_q  <= '0;
                    end else if (ref_cnt_q == RF_LAST) begin
                        if (!bus.bus_busy) begin
                            start_q <= 1'b1;
                            wait_q  <= 1'b1;
                            state_q <= RD;
                        end
                    end else begin
                        ref_cnt_q <= ref_cnt_q + 1'b1;
                    end
                end
                RD: begin
                    if (xfer_end) begin
                        state_q   <= IDLE;
                        ref_cnt_q <= '0;
                    end
                end
                PROG: begin
                    if (q_vec != prog_vec_q) state_q <= WB;
                end
                WB: begin
                    if (!wait_q) begin
                        if (!bus.bus_busy) begin
                            start_q <= 1'b1;
                            wr_q    <= 1'b1;
                            wait_q  <= 1'b1;
                        end
                    end else if (xfer_end) begin
                        state_q <= IDLE;
                        out_q   <= MODE_W'(MODE_IDLE);
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

    assign out           = out_q;
    assign init_done     = init_done_q;
    assign bus_err       = err_q;
    assign bus.bus_start = start_q;
    assign bus.bus_wr    = wr_q;

endmodule

// File: tb/tb_rtc_mode_ctrl.sv
// Self-checking bench for rtc_mode_ctrl: directed handshake/timing
// sequences, a table of switch vectors and randomized mode changes checked
// against a settle-level model of the mode rules.
module tb_rtc_mode_ctrl;

    localparam int DONE_DLY = 3;

    logic       clk     = 1'b0;
    logic       swreset = 1'b1;
    logic [2:0] sw      = 3'b000;
    logic [1:0] out;
    logic       init_done;
    logic       bus_err;

    rtc_mode_ctrl_if bif ();

    rtc_mode_ctrl #(
        .N_MODES      (3),
        .MODE_W       (2),
        .DEBOUNCE_CYC (4),
        .REFRESH_CYC  (100),
        .INIT_WRITES  (2),
        .TIMEOUT_CYC  (64)
    ) dut (
        .clk       (clk),
        .swreset   (swreset),
        .sw        (sw),
        .bus       (bif),
        .out       (out),
        .init_done (init_done),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bus transaction unit model ----------------
    bit withhold = 1'b0;
    int pend     = 0;

    initial begin
        bif.bus_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bif.bus_done = 1'b0;
            if (swreset) begin
                pend = 0;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) bif.bus_done = 1'b1;
            end else if (bif.bus_start && !withhold) begin
                pend = DONE_DLY;
            end
        end
    end

    // ---------------- monitor: one line per transaction ----------------
    int   n_wr = 0, n_rd = 0, start_long = 0, out_bad = 0;
    int   start_cyc[$];
    int   start_out[$];
    int   start_wr[$];
    int   done_cyc = -1, err_cyc = -1, idone_cyc = -1;
    logic start_prev = 1'b0, err_prev = 1'b0, idone_prev = 1'b0;

    always @(negedge clk) begin
        if (bif.bus_start) begin
            start_cyc.push_back(cyc);
            start_out.push_back(int'(out));
            start_wr.push_back(int'(bif.bus_wr));
            if (bif.bus_wr) n_wr++;
            else n_rd++;
            $display("[cyc %0d] txn %s out=%0d", cyc, bif.bus_wr ? "write" : "read", out);
        end
        if (bif.bus_start && start_prev) start_long++;
        start_prev = bif.bus_start;
        if (bif.bus_done) done_cyc = cyc;
        if (bus_err && !err_prev) err_cyc = cyc;
        err_prev = bus_err;
        if (init_done && !idone_prev) idone_cyc = cyc;
        idone_prev = init_done;
        if (!init_done && out != 2'd0) out_bad++;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    task automatic drv();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input int v, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (int'(out) == v) break;
            smp();
        end
        chk(name, int'(out), v);
    endtask

    task automatic wait_init(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (init_done) break;
            smp();
        end
        chk("init_done_rise", int'(init_done), 1);
    endtask

    task automatic wait_reads(input int target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (n_rd >= target) break;
            smp();
        end
        chk(name, n_rd, target);
    endtask

    // Reference rule: active mode is 1 + index of the lowest set switch, 0 if none.
    function automatic int mode_of(input logic [2:0] v);
        for (int b = 0; b < 3; b++) begin
            if (v[b]) return b + 1;
        end
        return 0;
    endfunction

    typedef struct {
        logic [2:0] sw;
        int         exp_out;
        int         exp_wb;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d required finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0, r0, s0, base, d1, s1, prev_out, exp_o, exp_w, bad;
        logic [2:0] prev_v, v;

        tbl[0] = '{3'b000, 0, 0};
        tbl[1] = '{3'b001, 1, 1};
        tbl[2] = '{3'b010, 2, 1};
        tbl[3] = '{3'b011, 1, 1};
        tbl[4] = '{3'b100, 3, 1};
        tbl[5] = '{3'b101, 1, 1};
        tbl[6] = '{3'b110, 2, 1};
        tbl[7] = '{3'b111, 1, 1};

        bif.bus_busy = 1'b0;

        // Reset state
        repeat (3) drv();
        smp();
        chk("rst_out", int'(out), 0);
        chk("rst_init_done", int'(init_done), 0);
        chk("rst_bus_err", int'(bus_err), 0);
        chk("rst_bus_start", int'(bif.bus_start), 0);
        chk("rst_bus_wr", int'(bif.bus_wr), 0);

        // 1: two configuration writes, init_done after the second done
        w0 = n_wr;
        drv();
        swreset = 1'b0;
        wait_init(60);
        chk("init_writes", n_wr - w0, 2);
        chk("init_reads", n_rd, 0);
        chk("init_done_after_2nd_done", idone_cyc, done_cyc + 1);

        // 2: refresh reads 100 cycles after entering IDLE
        wait_reads(1, 150, "refresh1_seen");
        chk("refresh1_delay", start_cyc[$] - idone_cyc, 100);
        chk("refresh1_is_read", start_wr[$], 0);
        repeat (6) smp();
        d1 = done_cyc;
        wait_reads(2, 150, "refresh2_seen");
        chk("refresh2_delay", start_cyc[$] - (d1 + 1), 100);

        // Table of switch vectors, each entered from IDLE and then released
        for (int k = 0; k < 8; k++) begin
            w0 = n_wr;
            drv();
            sw = tbl[k].sw;
            repeat (15) smp();
            chk($sformatf("tbl%0d_out", k), int'(out), tbl[k].exp_out);
            drv();
            sw = 3'b000;
            repeat (15) smp();
            chk($sformatf("tbl%0d_release", k), int'(out), 0);
            chk($sformatf("tbl%0d_writes", k), n_wr - w0, tbl[k].exp_wb);
        end

        // 3: exact latency 2+4+1, then write-back on release
        drv();
        sw = 3'b010;
        repeat (6) @(posedge clk);
        smp();
        chk("t3_before_latency", int'(out), 0);
        smp();
        chk("t3_at_latency", int'(out), 2);
        w0 = n_wr;
        drv();
        sw = 3'b000;
        wait_out(0, 30, "t3_release_idle");
        chk("t3_wb_count", n_wr - w0, 1);
        chk("t3_wb_out", start_out[$], 2);
        chk("t3_wb_is_write", start_wr[$], 1);

        // 4: time beats timer; direct change passes one IDLE cycle
        drv();
        sw = 3'b110;
        repeat (12) smp();
        chk("t4_time_wins", int'(out), 2);
        w0 = n_wr;
        drv();
        sw = 3'b100;
        for (int i = 0; i < 30; i++) begin
            if (out != 2'd2) break;
            smp();
        end
        chk("t4_idle_gap", int'(out), 0);
        smp();
        chk("t4_timer_mode", int'(out), 3);
        chk("t4_wb_count", n_wr - w0, 1);
        chk("t4_wb_out", start_out[$], 2);
        drv();
        sw = 3'b000;
        wait_out(0, 30, "t4_release_idle");

        // 5: bouncing bit0 never qualifies
        s0  = n_wr + n_rd;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            drv();
            if (k % 2 == 0) sw[0] = ~sw[0];
            if (out != 2'd0) bad++;
        end
        repeat (10) smp();
        chk("t5_out_during_bounce", bad, 0);
        chk("t5_out_after_bounce", int'(out), 0);
        chk("t5_no_bus_start", n_wr + n_rd - s0, 0);

        // Randomized mode changes against the settle model
        prev_v   = 3'b000;
        prev_out = 0;
        for (int k = 0; k < 12; k++) begin
            v     = 3'($urandom_range(7, 0));
            exp_o = mode_of(v);
            exp_w = (prev_out != 0 && v != prev_v) ? 1 : 0;
            w0    = n_wr;
            drv();
            sw = v;
            repeat ($urandom_range(40, 24)) smp();
            $display("[cyc %0d] rand step %0d sw=%b out=%0d", cyc, k, v, out);
            chk($sformatf("rnd%0d_out", k), int'(out), exp_o);
            chk($sformatf("rnd%0d_writes", k), n_wr - w0, exp_w);
            if (exp_w == 1) chk($sformatf("rnd%0d_wb_out", k), start_out[$], prev_out);
            prev_v   = v;
            prev_out = exp_o;
        end
        drv();
        sw = 3'b000;
        repeat (30) smp();
        chk("rnd_final_idle", int'(out), 0);

        // 6a: withheld done on a read -> timeout after 64 cycles, back in IDLE
        chk("pre_timeout_err", int'(bus_err), 0);
        withhold = 1'b1;
        r0 = n_rd;
        wait_reads(r0 + 1, 150, "to_read_seen");
        s1 = start_cyc[$];
        for (int i = 0; i < 100; i++) begin
            if (bus_err) break;
            smp();
        end
        chk("to_bus_err", int'(bus_err), 1);
        chk("to_delay", err_cyc - s1, 64);
        withhold = 1'b0;
        wait_reads(r0 + 2, 150, "to_next_read_seen");
        chk("to_back_in_idle", start_cyc[$] - err_cyc, 100);
        chk("to_err_sticky", int'(bus_err), 1);

        // 6b: swreset in PROG clears asynchronously, restarts INIT without write-back
        drv();
        sw = 3'b001;
        wait_out(1, 30, "rst_prog_entered");
        @(posedge clk);
        #3;
        swreset = 1'b1;
        #1;
        chk("rst_async_out", int'(out), 0);
        chk("rst_async_err", int'(bus_err), 0);
        chk("rst_async_init_done", int'(init_done), 0);
        sw = 3'b000;
        repeat (3) drv();
        base = start_cyc.size();
        w0   = n_wr;
        r0   = n_rd;
        swreset = 1'b0;
        wait_init(60);
        chk("reinit_writes", n_wr - w0, 2);
        chk("reinit_reads", n_rd - r0, 0);
        if (start_cyc.size() > base) chk("reinit_first_out", start_out[base], 0);
        else chk("reinit_first_txn", start_cyc.size(), base + 1);

        // Global protocol properties
        chk("start_single_cycle", start_long, 0);
        chk("out_zero_before_init", out_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rtc_mode_ctrl.md
Name: rtc_mode_ctrl

Overview:
- Parametrised main control FSM of the RTC, the next generation of the original 3-switch (date/time/timer) mode machine.
- Accepts N_MODES debounced programming switches and reports the active mode on out.
- Sequences RTC bus transactions through a start/busy/done handshake: initial configuration writes, periodic refresh reads, and write-back on leaving a programming mode.
- Sits between the board switches and the RTC bus-transaction unit; its out drives the display/edit datapath.

Parameters:
N_MODES, 3, number of programming modes/switches (bit0 date, bit1 time, bit2 timer)
MODE_W, 2, width of out; must equal clog2(N_MODES+1)
DEBOUNCE_CYC, 4, consecutive stable cycles required to qualify a switch vector
REFRESH_CYC, 100, IDLE cycles between refresh reads
INIT_WRITES, 2, configuration writes issued after reset
TIMEOUT_CYC, 64, max cycles waiting for bus_done before abort

Ports:
clk  in  1  system clock, rising edge
swreset  in  1  reset, asynchronous, active-high
sw  in  N_MODES  raw mode switches, asynchronous to clk
bus_busy  in  1  transaction unit busy
bus_done  in  1  one-cycle pulse: transaction complete
out  out  MODE_W  active mode code: 0 = display/idle, k+1 = programming mode k
bus_start  out  1  one-cycle transaction request pulse
bus_wr  out  1  1 = write, 0 = read; valid while bus_start = 1
init_done  out  1  high once all INIT_WRITES have completed
bus_err  out  1  sticky timeout flag, cleared only by swreset

Behaviour:
- Reset values:
  - out = 0, bus_start = 0, bus_wr = 0, init_done = 0, bus_err = 0.
  - State INIT; all counters 0; qualified vector q = 0.
  - swreset asserted mid-operation aborts immediately; no write-back is issued.
- Switch path:
  - 2-FF synchroniser, then debounce.
  - q takes the synced vector after it has been unchanged for DEBOUNCE_CYC consecutive cycles.
  - Latency from sw edge to q update: 2 + DEBOUNCE_CYC cycles.
- Selection: sel = lowest set index of q (date > time > timer); sel_valid = |q.
- Handshake:
  - bus_start is asserted only in a cycle with bus_busy = 0, for exactly one cycle per transaction.
  - The state then waits for bus_done.
  - bus_done in a non-waiting state is ignored.
  - A timeout counter runs while waiting. On reaching TIMEOUT_CYC: bus_err = 1, transaction abandoned, next state as if done.
- States:
  - INIT: issue write (bus_wr = 1); on done, increment count. After the INIT_WRITES-th done: init_done = 1, go to IDLE. Switches are ignored in INIT. With INIT_WRITES = 0, go straight to IDLE with init_done = 1.
  - IDLE:
    - out = 0; refresh counter increments.
    - If sel_valid: go to PROG, out = sel+1 from the next cycle, refresh counter cleared. This has priority over a refresh firing in the same cycle.
    - Else if counter == REFRESH_CYC-1 and bus_busy = 0: bus_start read, go to RD.
    - If bus_busy blocks, the counter saturates at REFRESH_CYC-1.
  - RD: on done or timeout, go to IDLE with refresh counter = 0. q changes are not acted on until IDLE.
  - PROG: out held at the latched sel+1. Any change of q (to 0 or another nonzero vector) goes to WB.
  - WB:
    - out stays at the old mode code; issue write (bus_wr = 1).
    - On done or timeout: go to IDLE, out = 0. IDLE re-evaluates q next cycle, so a direct mode change passes through one write-back plus one IDLE cycle.
- Widths: counters sized by clog2 of their parameter. Counter terminal values are compared with ==, never wrapped.

Decomposition:
- Shared package rtc_pkg:
  - state enum (INIT, IDLE, RD, PROG, WB)
  - mode code constants MODE_IDLE = 0, MODE_DATE = 1, MODE_TIME = 2, MODE_TIMER = 3
  - clog2 helper function
- One sub-module: rtc_sw_debounce (parameter W, DEBOUNCE_CYC; synchroniser + stability counter, outputs q).

Test Plan:
1. Reset, then bus_done each request 3 cycles after bus_start, INIT_WRITES = 2 → exactly 2 write pulses, init_done = 1 after the 2nd done, out = 0 throughout.
2. IDLE with sw = 0 → read bus_start (bus_wr = 0) exactly 100 cycles after entering IDLE, then again 100 cycles after each done.
3. sw = 3'b010 held → out = 2 at 2+4+1 cycles after the edge. Release → one write pulse with out = 2, then out = 0 after done.
4. sw = 3'b110 → out = 2 (time beats timer). Change to 3'b100 → write-back, one IDLE cycle, then out = 3.
5. Bounce sw bit0 every 2 cycles for 20 cycles → q never updates, out stays 0, no bus_start.
6. Withhold bus_done on a read → bus_err = 1 after 64 cycles, FSM back in IDLE. Assert swreset mid-PROG → out = 0 asynchronously, FSM restarts in INIT with no write-back.
